opll_audio_dac: RTL
===================

Name: opll_audio_dac

Overview:
- Parametrised 1-bit/parallel audio output stage for the OPLL core. It replaces the current sign-bit-only "PWM" output.
- Captures the signed accumulator sample on its strobe, applies a saturating gain shift and converts it to offset-binary.
- Drives one pin as raw-sign, PWM, 1st-order or 2nd-order sigma-delta (runtime-selectable), plus a parallel unsigned MSB bus.
- Sits between the synth core's accumulator outputs and the top-level uo_out/uio_out pins.

Parameters:
- IN_W, 16: signed input sample width.
- PWM_W, 8: PWM counter/duty resolution (PWM_W <= IN_W).
- OUT_PAR_W, 8: parallel output width (OUT_PAR_W <= IN_W).
- INT_W, IN_W+4: signed width of the sigma-delta integrators.

Ports:
- clk  in  1  single clock, same clock as the synth core.
- rst  in  1  reset, asynchronous, active-high.
- i_sample  in  IN_W  signed PCM sample from the accumulator.
- i_strb  in  1  sample-valid strobe; 1-cycle pulse.
- i_mode  in  2  0=legacy sign, 1=PWM, 2=DSM1, 3=DSM2.
- i_gain_shift  in  3  arithmetic left shift 0..7, saturating.
- o_bit  out  1  1-bit audio output (registered).
- o_par  out  OUT_PAR_W  offset-binary MSBs of the latched sample.
- o_valid  out  1  1-cycle pulse when o_par/latch update.
- o_clip  out  1  high while the latched sample was saturated.

Behaviour:
- Reset (async, all registers):
  - o_bit=0, o_valid=0, o_clip=0.
  - o_par=2^(OUT_PAR_W-1) (midscale); sample latch u_q=2^(IN_W-1).
  - sign_q=0, PWM counter=0, duty_q=0, integrators=0, mode_q=0.
- Capture (edge with i_strb=1):
  - g = i_sample <<< i_gain_shift, saturated to [-2^(IN_W-1), 2^(IN_W-1)-1].
  - u_q = g with MSB inverted; sign_q = i_sample[IN_W-1] (pre-gain).
  - o_par = u_q[IN_W-1 -: OUT_PAR_W]; o_clip = saturation occurred.
  - o_valid=1 for exactly that cycle. Latency: strobe edge -> outputs valid next cycle (1 clk).
- Mode tracking: mode_q <= i_mode every clk.
  - If i_mode != mode_q on an edge: PWM counter and both integrators clear, DSM1 accumulator clears, o_bit=0 for that cycle.
  - Normal operation resumes on the following edge.
- Mode 0 (legacy): o_bit = sign_q, updated with the strobe. Bit-compatible with the existing sign-bit output.
- Mode 1 (PWM):
  - Counter runs PWM_W bits, +1 per clk, wraps max->0.
  - duty_q loads u_q[IN_W-1 -: PWM_W] on the edge where the counter == max.
  - o_bit <= (counter < duty_q).
  - duty 0 -> constant 0; duty max -> high for 2^PWM_W-1 of 2^PWM_W cycles.
  - Strobe on the wrap edge: duty_q takes the pre-edge u_q; the new sample applies at the next wrap.
- Mode 2 (DSM1):
  - IN_W-bit accumulator; each clk {carry,acc} <= acc + u_q; o_bit <= carry.
  - Ones density = u_q / 2^IN_W exactly over 2^IN_W cycles.
- Mode 3 (DSM2):
  - x = u_q - 2^(IN_W-1) (signed); fb = o_bit ? +2^(IN_W-1) : -2^(IN_W-1).
  - i1 <= sat(i1 + x - fb); i2 <= sat(i2 + i1 - fb); o_bit <= (i2_next >= 0).
  - Saturation is to INT_W signed limits.
- A mid-operation strobe never disturbs the counters/integrators; only u_q changes.
- Simultaneous strobe and mode change: the capture happens and the mode clear happens, both on that edge.

Decomposition:
- Package opll_dac_pkg: mode encoding constants (MODE_LEGACY, MODE_PWM, MODE_DSM1, MODE_DSM2) and the saturate-shift function.
- One sub-module, opll_dac_dsm2: second-order modulator with integrator saturation; inputs u_q, clear, enable; output bit.
- PWM and DSM1 logic stay inline.

Test Plan (IN_W=16, PWM_W=8, OUT_PAR_W=8):
- Assert rst mid-run in mode 3 -> o_bit=0, o_par=0x80, o_valid=0, o_clip=0 immediately (async). No output toggles until after release.
- Mode 0, shift 0: strobe 0x8000 -> o_bit=1 and o_valid=1 next cycle. Then strobe 0x0001 -> o_bit=0, o_par=0x80.
- Gain saturation:
  - shift 2, sample 0x3000 -> o_clip=1, o_par=0xFF.
  - shift 1, sample 0xC000 -> 0x8000 exactly, o_clip=0, o_par=0x00.
- Mode 1, sample 0x4000 (duty 0xC0):
  - After the next wrap, each 256-cycle period has exactly 192 high cycles.
  - Sample 0x8000 -> o_bit constantly 0.
- Mode 2:
  - Sample 0x0000 -> o_bit alternates 0,1,0,1 from the clear.
  - Sample 0x4000 -> exactly 49152 ones in 65536 cycles.
- Mode 3, sample 0x2000 -> ones in 4096 cycles = 2560±4 and integrators never hit saturation. Switching to mode 1 mid-stream -> integrators and counter read 0 on the next cycle.

Source files
------------

// File: rtl/opll_dac_pkg.sv
// Shared definitions for the OPLL audio output stage: mode encoding and the
// saturating gain shift applied to captured samples.
package opll_dac_pkg;

  typedef enum logic [1:0] {
    MODE_LEGACY = 2'd0,
    MODE_PWM    = 2'd1,
    MODE_DSM1   = 2'd2,
    MODE_DSM2   = 2'd3
  } dac_mode_e;

  // Arithmetic left shift clamped to an i_w-bit signed range; o_clip flags clamping.
  function automatic logic signed [63:0] sat_shift(
    input  logic signed [63:0] i_val,
    input  logic        [2:0]  i_sh,
    input  int                 i_w,
    output logic               o_clip
  );
    logic signed [63:0] v_g;
    logic signed [63:0] v_hi;
    logic signed [63:0] v_lo;
    v_g    = i_val <<< i_sh;
    v_hi   = (64'sd1 <<< (i_w - 1)) - 64'sd1;
    v_lo   = -v_hi - 64'sd1;
    o_clip = 1'b0;
    if (v_g > v_hi) begin
      o_clip = 1'b1;
      v_g    = v_hi;
    end else if (v_g < v_lo) begin
      o_clip = 1'b1;
      v_g    = v_lo;
    end
    return v_g;
  endfunction

endpackage

// File: rtl/opll_dac_dsm2.sv
// Second-order 1-bit sigma-delta modulator with saturating integrators.
// The second integrator consumes the freshly updated first integrator, giving NTF (1-z^-1)^2.
module opll_dac_dsm2
  import opll_dac_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int INT_W = IN_W + 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] i_u_q,
  input  logic            i_clear,
  input  logic            i_enable,
  output logic            o_bit
);
  localparam int EXT_W = INT_W + 2;
  localparam logic signed [EXT_W-1:0] FB_MAG = {{(EXT_W-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] LIM_HI = {{(EXT_W-INT_W+1){1'b0}}, {(INT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] LIM_LO = {{(EXT_W-INT_W+1){1'b1}}, {(INT_W-1){1'b0}}};

  logic signed [INT_W-1:0] r_i1;
  logic signed [INT_W-1:0] r_i2;
  logic                    r_bit;

  logic signed [EXT_W-1:0] w_x;
  logic signed [EXT_W-1:0] w_fb;
  logic signed [EXT_W-1:0] w_i1_sum;
  logic signed [EXT_W-1:0] w_i2_sum;
  logic signed [INT_W-1:0] w_i1_nxt;
  logic signed [INT_W-1:0] w_i2_nxt;

  function automatic logic signed [INT_W-1:0] sat_int(input logic signed [EXT_W-1:0] i_v);
    if (i_v > LIM_HI) return LIM_HI[INT_W-1:0];
    if (i_v < LIM_LO) return LIM_LO[INT_W-1:0];
    return i_v[INT_W-1:0];
  endfunction

  always_comb begin
    // Offset-binary back to two's complement: flip the MSB, then sign-extend.
    w_x      = {{(EXT_W-IN_W+1){~i_u_q[IN_W-1]}}, i_u_q[IN_W-2:0]};
    w_fb     = r_bit ? FB_MAG : -FB_MAG;
    w_i1_sum = {{2{r_i1[INT_W-1]}}, r_i1} + w_x - w_fb;
    w_i1_nxt = sat_int(w_i1_sum);
    w_i2_sum = {{2{r_i2[INT_W-1]}}, r_i2} + {{2{w_i1_nxt[INT_W-1]}}, w_i1_nxt} - w_fb;
    w_i2_nxt = sat_int(w_i2_sum);
  end

  assign o_bit = ~w_i2_nxt[INT_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_bit <= 1'b0;
    end else if (i_clear) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_bit <= 1'b0;
    end else if (i_enable) begin
      r_i1  <= w_i1_nxt;
      r_i2  <= w_i2_nxt;
      r_bit <= o_bit;
    end
  end

endmodule

// File: rtl/opll_audio_dac.sv
// OPLL audio output stage: latches the accumulator sample with saturating gain,
// and drives a 1-bit pin (sign / PWM / DSM1 / DSM2) plus a parallel offset-binary bus.
module opll_audio_dac
  import opll_dac_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int PWM_W     = 8,
  parameter int OUT_PAR_W = 8,
  parameter int INT_W     = IN_W + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] i_sample,
  input  logic                   i_strb,
  input  logic        [1:0]      i_mode,
  input  logic        [2:0]      i_gain_shift,
  output logic                   o_bit,
  output logic [OUT_PAR_W-1:0]   o_par,
  output logic                   o_valid,
  output logic                   o_clip
);
  localparam logic [IN_W-1:0]      U_MID   = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [OUT_PAR_W-1:0] PAR_MID = {1'b1, {(OUT_PAR_W-1){1'b0}}};

  logic [IN_W-1:0]      r_u_q;
  logic                 r_sign_q;
  logic                 r_bit;
  logic [OUT_PAR_W-1:0] r_par;
  logic                 r_valid;
  logic                 r_clip;
  logic [1:0]           r_mode_q;
  logic [PWM_W-1:0]     r_pwm_cnt;
  logic [PWM_W-1:0]     r_duty_q;
  logic [IN_W-1:0]      r_acc1;

  logic [IN_W-1:0] w_gain;
  logic [IN_W-1:0] w_u_new;
  logic            w_clip;
  logic            w_mode_chg;
  logic [IN_W:0]   w_acc1_sum;
  logic            w_dsm2_bit;

  always_comb begin
    w_clip     = 1'b0;
    w_gain     = IN_W'(sat_shift(64'(i_sample), i_gain_shift, IN_W, w_clip));
    w_u_new    = {~w_gain[IN_W-1], w_gain[IN_W-2:0]};
    w_mode_chg = (i_mode != r_mode_q);
    w_acc1_sum = {1'b0, r_acc1} + {1'b0, r_u_q};
  end

  opll_dac_dsm2 #(.IN_W(IN_W), .INT_W(INT_W)) u_dsm2 (
    .clk      (clk),
    .rst      (rst),
    .i_u_q    (r_u_q),
    .i_clear  (w_mode_chg),
    .i_enable (r_mode_q == MODE_DSM2),
    .o_bit    (w_dsm2_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_u_q     <= U_MID;
      r_sign_q  <= 1'b0;
      r_bit     <= 1'b0;
      r_par     <= PAR_MID;
      r_valid   <= 1'b0;
      r_clip    <= 1'b0;
      r_mode_q  <= MODE_LEGACY;
      r_pwm_cnt <= '0;
      r_duty_q  <= '0;
      r_acc1    <= '0;
    end else begin
      r_mode_q <= i_mode;
      r_valid  <= i_strb;
      if (i_strb) begin
        r_u_q    <= w_u_new;
        r_sign_q <= i_sample[IN_W-1];
        r_par    <= w_u_new[IN_W-1 -: OUT_PAR_W];
        r_clip   <= w_clip;
      end
      // A mode switch restarts every modulator from a known state with the pin low.
      if (w_mode_chg) begin
        r_pwm_cnt <= '0;
        r_acc1    <= '0;
        r_bit     <= 1'b0;
      end else begin
        case (r_mode_q)
          MODE_LEGACY: r_bit <= i_strb ? i_sample[IN_W-1] : r_sign_q;
          MODE_PWM: begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            if (&r_pwm_cnt) r_duty_q <= r_u_q[IN_W-1 -: PWM_W];
            r_bit <= (r_pwm_cnt < r_duty_q);
          end
          MODE_DSM1: begin
            r_acc1 <= w_acc1_sum[IN_W-1:0];
            r_bit  <= w_acc1_sum[IN_W];
          end
          default: r_bit <= w_dsm2_bit;
        endcase
      end
    end
  end

  assign o_bit   = r_bit;
  assign o_par   = r_par;
  assign o_valid = r_valid;
  assign o_clip  = r_clip;

endmodule
